// File: rtl/phy_apb_pkg.sv
// Shared definitions for the PHY APB completer: width defaults, register
// addresses, register bit positions and the transfer FSM state encoding.
package phy_apb_pkg;

  localparam int unsigned AWIDTH_DEF = 18;
  localparam int unsigned DWIDTH_DEF = 32;
  localparam int unsigned REG_W      = 32;
  localparam int unsigned WAIT_CNT_W = 4;

  localparam logic [17:0] ADDR_SCRATCH = 18'h3_0060;
  localparam logic [17:0] ADDR_STATUS  = 18'h3_0064;
  localparam logic [17:0] ADDR_CTRL    = 18'h3_0068;

  localparam int unsigned STATUS_INIT_BIT = 0;
  localparam int unsigned STATUS_CNT_LSB  = 16;
  localparam int unsigned STATUS_CNT_W    = 16;
  localparam int unsigned CTRL_LANE_LSB   = 0;
  localparam int unsigned CTRL_LANE_W     = 4;
  localparam int unsigned CTRL_START_BIT  = 28;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/phy_apb_regbank.sv
// Register storage and address decode for the PHY APB completer.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   addr_i, wdata_i     - latched transfer address / write data
//   write_i             - latched transfer direction (1 = write)
//   commit_i            - high on the RESP cycle of a non-aborted transfer
//   uc_init_complete_i  - microcontroller init-done level
//   rdata_c_o, err_c_o  - combinational read data / error decode of addr_i
//   lane_cfg_o          - CTRL lane configuration
//   uc_start_o          - one-cycle start pulse after a CTRL start write
// Requires DWIDTH >= 32.
module phy_apb_regbank
  import phy_apb_pkg::*;
#(
  parameter int unsigned AWIDTH = AWIDTH_DEF,
  parameter int unsigned DWIDTH = DWIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AWIDTH-1:0]      addr_i,
  input  logic [DWIDTH-1:0]      wdata_i,
  input  logic                   write_i,
  input  logic                   commit_i,
  input  logic                   uc_init_complete_i,
  output logic [DWIDTH-1:0]      rdata_c_o,
  output logic                   err_c_o,
  output logic [CTRL_LANE_W-1:0] lane_cfg_o,
  output logic                   uc_start_o
);

  logic [REG_W-1:0]        scratch_q;
  logic                    init_done_q;
  logic                    init_prev_q;
  logic [STATUS_CNT_W-1:0] xfer_cnt_q;
  logic [CTRL_LANE_W-1:0]  lane_cfg_q;
  logic                    uc_start_q;

  logic                    sel_scratch_c;
  logic                    sel_status_c;
  logic                    sel_ctrl_c;
  logic [REG_W-1:0]        rdata32_c;
  logic                    err_c;
  logic [REG_W-1:0]        wdata32_c;
  logic                    wr_c;
  logic                    init_rise_c;

  assign sel_scratch_c = (addr_i == AWIDTH'(ADDR_SCRATCH));
  assign sel_status_c  = (addr_i == AWIDTH'(ADDR_STATUS));
  assign sel_ctrl_c    = (addr_i == AWIDTH'(ADDR_CTRL));
  assign wdata32_c     = REG_W'(wdata_i);

  // Read mux and error decode; errors always read back as zero.
  always_comb begin
    rdata32_c = '0;
    err_c     = 1'b0;
    if (addr_i[1:0] != 2'b00) begin
      err_c = 1'b1;
    end else if (sel_scratch_c) begin
      rdata32_c = scratch_q;
    end else if (sel_status_c) begin
      rdata32_c[STATUS_CNT_LSB +: STATUS_CNT_W] = xfer_cnt_q;
      rdata32_c[STATUS_INIT_BIT]                = init_done_q;
    end else if (sel_ctrl_c) begin
      rdata32_c[CTRL_LANE_LSB +: CTRL_LANE_W] = lane_cfg_q;
    end else begin
      err_c = 1'b1;
    end
  end

  assign wr_c        = commit_i && write_i && !err_c;
  assign init_rise_c = uc_init_complete_i && !init_prev_q;

  // Register state; a rising init edge beats a same-cycle W1C.
  always_ff @(posedge clk) begin
    if (rst) begin
      scratch_q   <= '0;
      init_done_q <= 1'b0;
      init_prev_q <= 1'b0;
      xfer_cnt_q  <= '0;
      lane_cfg_q  <= '0;
      uc_start_q  <= 1'b0;
    end else begin
      init_prev_q <= uc_init_complete_i;
      uc_start_q  <= 1'b0;
      if (wr_c && sel_scratch_c) begin
        scratch_q <= wdata32_c;
      end
      if (wr_c && sel_ctrl_c) begin
        lane_cfg_q <= wdata32_c[CTRL_LANE_LSB +: CTRL_LANE_W];
        uc_start_q <= wdata32_c[CTRL_START_BIT];
      end
      if (init_rise_c) begin
        init_done_q <= 1'b1;
      end else if (wr_c && sel_status_c && wdata32_c[STATUS_INIT_BIT]) begin
        init_done_q <= 1'b0;
      end
      if (commit_i && !err_c) begin
        xfer_cnt_q <= xfer_cnt_q + STATUS_CNT_W'(1);
      end
    end
  end

  assign rdata_c_o  = DWIDTH'(rdata32_c);
  assign err_c_o    = err_c;
  assign lane_cfg_o = lane_cfg_q;
  assign uc_start_o = uc_start_q;

endmodule

// File: rtl/phy_apb_completer.sv
// APB3 completer for the PHY control registers (SCRATCH, STATUS, CTRL).
// Ports:
//   clk, rst                   - clock, synchronous active-high reset
//   paddr, psel, penable,
//   pwrite, pwdata             - APB3 requester inputs
//   prdata, pready, pslverr    - registered APB3 response
//   uc_init_complete           - microcontroller init-done level
//   uc_start                   - one-cycle microcontroller start pulse
//   lane_cfg                   - lane configuration from CTRL
module phy_apb_completer
  import phy_apb_pkg::*;
#(
  parameter int unsigned AWIDTH      = AWIDTH_DEF,
  parameter int unsigned DWIDTH      = DWIDTH_DEF,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] paddr,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [DWIDTH-1:0] pwdata,
  output logic [DWIDTH-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic              uc_init_complete,
  output logic              uc_start,
  output logic [3:0]        lane_cfg
);

  state_e                  state_q;
  logic [AWIDTH-1:0]       addr_q;
  logic [DWIDTH-1:0]       wdata_q;
  logic                    write_q;
  logic [WAIT_CNT_W-1:0]   cnt_q;
  logic [DWIDTH-1:0]       prdata_q;
  logic                    pready_q;
  logic                    pslverr_q;

  logic [DWIDTH-1:0]       rdata_c;
  logic                    err_c;
  logic                    commit_c;

  // Writes and the transfer count only take effect if psel holds through RESP.
  assign commit_c = (state_q == ST_RESP) && psel;

  // Transfer FSM with registered response; prdata is zero unless pready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      cnt_q     <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (psel && !penable) begin
            addr_q  <= paddr;
            wdata_q <= pwdata;
            write_q <= pwrite;
            cnt_q   <= '0;
            state_q <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!psel) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + WAIT_CNT_W'(1);
            if (cnt_q == WAIT_CNT_W'(WAIT_STATES)) begin
              state_q   <= ST_RESP;
              pready_q  <= 1'b1;
              pslverr_q <= err_c;
              prdata_q  <= rdata_c;
            end
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  phy_apb_regbank #(
    .AWIDTH (AWIDTH),
    .DWIDTH (DWIDTH)
  ) u_regbank (
    .clk                (clk),
    .rst                (rst),
    .addr_i             (addr_q),
    .wdata_i            (wdata_q),
    .write_i            (write_q),
    .commit_i           (commit_c),
    .uc_init_complete_i (uc_init_complete),
    .rdata_c_o          (rdata_c),
    .err_c_o            (err_c),
    .lane_cfg_o         (lane_cfg),
    .uc_start_o         (uc_start)
  );

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_phy_apb_completer.sv
// Directed self-checking bench for phy_apb_completer (WAIT_STATES = 2).
module tb_phy_apb_completer;

  localparam logic [17:0] A_SCRATCH = 18'h3_0060;
  localparam logic [17:0] A_STATUS  = 18'h3_0064;
  localparam logic [17:0] A_CTRL    = 18'h3_0068;
  localparam int          LAT       = 4;

  logic        clk;
  logic        rst;
  logic [17:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        uc_init_complete;
  logic        uc_start;
  logic [3:0]  lane_cfg;

  int          n_checks;
  int          n_fail;
  logic [15:0] exp_cnt;
  logic        start_at_resp;

  phy_apb_completer #(
    .AWIDTH      (18),
    .DWIDTH      (32),
    .WAIT_STATES (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .paddr            (paddr),
    .psel             (psel),
    .penable          (penable),
    .pwrite           (pwrite),
    .pwdata           (pwdata),
    .prdata           (prdata),
    .pready           (pready),
    .pslverr          (pslverr),
    .uc_init_complete (uc_init_complete),
    .uc_start         (uc_start),
    .lane_cfg         (lane_cfg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One APB transfer; returns at the falling edge of the cycle after RESP.
  task automatic apb(input logic wr, input logic [17:0] a, input logic [31:0] wd,
                     input bit raise_init, output logic [31:0] rd, output logic err,
                     output int lat);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    @(negedge clk);
    penable = 1'b1;
    lat = 1;
    while (pready !== 1'b1 && lat < 16) begin
      @(negedge clk);
      lat++;
    end
    rd            = prdata;
    err           = pslverr;
    start_at_resp = uc_start;
    if (raise_init) uc_init_complete = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic xfer(input string tag, input logic wr, input logic [17:0] a,
                      input logic [31:0] wd, input logic [31:0] exp_rd,
                      input logic exp_err, input bit raise_init);
    logic [31:0] rd;
    logic        err;
    int          lat;
    apb(wr, a, wd, raise_init, rd, err, lat);
    chk({tag, "_lat"}, 32'(lat), 32'(LAT));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    if (!wr) chk({tag, "_rd"}, rd, exp_rd);
    if (!exp_err) exp_cnt = exp_cnt + 16'd1;
  endtask

  initial begin
    int seen;
    logic [31:0] rd;
    logic        err;
    int          lat;
    n_checks = 0; n_fail = 0; exp_cnt = 16'd0; start_at_resp = 1'b0;
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; uc_init_complete = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pready", 32'(pready), 32'd0);
    chk("rst_prdata", prdata, 32'd0);
    chk("rst_pslverr", 32'(pslverr), 32'd0);
    chk("rst_uc_start", 32'(uc_start), 32'd0);
    chk("rst_lane_cfg", 32'(lane_cfg), 32'd0);
    rst = 1'b0;

    // SCRATCH write/read
    xfer("wr_scratch", 1'b1, A_SCRATCH, 32'hA5A5_5A5A, 32'h0, 1'b0, 1'b0);
    xfer("rd_scratch", 1'b0, A_SCRATCH, 32'h0, 32'hA5A5_5A5A, 1'b0, 1'b0);

    // CTRL write with start
    apb(1'b1, A_CTRL, 32'h1000_0003, 1'b0, rd, err, lat);
    exp_cnt = exp_cnt + 16'd1;
    chk("wr_ctrl_lat", 32'(lat), 32'(LAT));
    chk("wr_ctrl_err", 32'(err), 32'd0);
    chk("uc_start_at_resp", 32'(start_at_resp), 32'd0);
    chk("uc_start_after_resp", 32'(uc_start), 32'd1);
    chk("lane_cfg", 32'(lane_cfg), 32'h3);
    @(negedge clk);
    chk("uc_start_one_cycle", 32'(uc_start), 32'd0);
    xfer("rd_ctrl", 1'b0, A_CTRL, 32'h0, 32'h0000_0003, 1'b0, 1'b0);

    // STATUS: init_done set, W1C, set-wins
    xfer("rd_status0", 1'b0, A_STATUS, 32'h0, {exp_cnt, 15'h0, 1'b0}, 1'b0, 1'b0);
    uc_init_complete = 1'b1;
    repeat (2) @(negedge clk);
    xfer("rd_status_init", 1'b0, A_STATUS, 32'h0, {exp_cnt, 15'h0, 1'b1}, 1'b0, 1'b0);
    xfer("w1c_status", 1'b1, A_STATUS, 32'h1, 32'h0, 1'b0, 1'b0);
    xfer("rd_status_clr", 1'b0, A_STATUS, 32'h0, {exp_cnt, 15'h0, 1'b0}, 1'b0, 1'b0);
    uc_init_complete = 1'b0;
    repeat (2) @(negedge clk);
    xfer("w1c_set_wins", 1'b1, A_STATUS, 32'h1, 32'h0, 1'b0, 1'b1);
    xfer("rd_status_setwin", 1'b0, A_STATUS, 32'h0, {exp_cnt, 15'h0, 1'b1}, 1'b0, 1'b0);

    // Error responses leave xfer_cnt alone
    xfer("rd_unmapped", 1'b0, 18'h3_0070, 32'h0, 32'h0, 1'b1, 1'b0);
    xfer("rd_misalign", 1'b0, 18'h3_0061, 32'h0, 32'h0, 1'b1, 1'b0);
    xfer("wr_misalign", 1'b1, 18'h3_0062, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
    xfer("rd_status_noinc", 1'b0, A_STATUS, 32'h0, {exp_cnt, 15'h0, 1'b1}, 1'b0, 1'b0);

    // penable high in IDLE is not a setup
    @(negedge clk);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = A_SCRATCH;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (pready === 1'b1) seen++;
    end
    chk("idle_penable_ignored", 32'(seen), 32'd0);
    psel = 1'b0; penable = 1'b0;

    // Abort during ACCESS
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = A_SCRATCH; pwdata = 32'h1234_5678;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (pready === 1'b1) seen++;
    end
    chk("abort_no_pready", 32'(seen), 32'd0);
    xfer("rd_scratch_kept", 1'b0, A_SCRATCH, 32'h0, 32'hA5A5_5A5A, 1'b0, 1'b0);

    // Reset on the cycle the transfer would enter RESP
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = A_CTRL; pwdata = 32'h1000_0005;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_pready", 32'(pready), 32'd0);
    chk("mid_rst_prdata", prdata, 32'd0);
    chk("mid_rst_pslverr", 32'(pslverr), 32'd0);
    chk("mid_rst_uc_start", 32'(uc_start), 32'd0);
    chk("mid_rst_lane_cfg", 32'(lane_cfg), 32'd0);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 16'd0;
    xfer("rd_ctrl_post_rst", 1'b0, A_CTRL, 32'h0, 32'h0, 1'b0, 1'b0);
    xfer("rd_scratch_post_rst", 1'b0, A_SCRATCH, 32'h0, 32'h0, 1'b0, 1'b0);
    xfer("rd_status_post_rst", 1'b0, A_STATUS, 32'h0, {exp_cnt, 15'h0, 1'b1}, 1'b0, 1'b0);

    // Counter wrap from 0xFFFF
    @(negedge clk);
    force dut.u_regbank.xfer_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.u_regbank.xfer_cnt_q;
    exp_cnt = 16'hFFFF;
    xfer("rd_status_ffff", 1'b0, A_STATUS, 32'h0, {exp_cnt, 15'h0, 1'b1}, 1'b0, 1'b0);
    xfer("rd_status_wrap", 1'b0, A_STATUS, 32'h0, {16'h0000, 15'h0, 1'b1}, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
